rf_fill_dump_engine: RTL and testbench
======================================

# rf_fill_dump_engine

Initiator-side controller for the 32 x 32-bit two-read/one-write register file. It drives the register file's write and read ports: a FILL command writes a deterministic pattern into registers 1..31, and a DUMP command walks all 32 registers two at a time through both read ports. DUMP streams the register pairs out on a valid/ready interface with backpressure. It is used for bring-up, self-test and debug readout of the register file.

## Interface
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register index width
- NUM_REGS, 32, register count (even; fixed at 2**ADDR_WIDTH)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  one clock; reset is synchronous and active-high
- Start_Fill_i  in  1  fill request, sampled in IDLE only
- Start_Dump_i  in  1  dump request, sampled in IDLE only
- Seed_i  in  DATA_WIDTH  fill base value, captured with Start_Fill_i
- Busy_o  out  1  high whenever state != IDLE
- Done_o  out  1  one-cycle pulse at command completion
- Reg_Write_o  out  1  register file write enable
- Write_Register_o  out  ADDR_WIDTH  write index
- Write_Data_o  out  DATA_WIDTH  write data
- Read_Register_1_o  out  ADDR_WIDTH  read port 1 index (even register)
- Read_Register_2_o  out  ADDR_WIDTH  read port 2 index (odd register)
- Read_Data_1_i  in  DATA_WIDTH  asynchronous read data, port 1
- Read_Data_2_i  in  DATA_WIDTH  asynchronous read data, port 2
- Dump_Valid_o  out  1  dump beat valid
- Dump_Ready_i  in  1  downstream accepts beat
- Dump_Index_o  out  ADDR_WIDTH  even register index of the beat
- Dump_Data_1_o  out  DATA_WIDTH  contents of register Dump_Index_o
- Dump_Data_2_o  out  DATA_WIDTH  contents of register Dump_Index_o+1

## Operation
- States: IDLE, FILL, DUMP, DONE.
- Transitions:
  - IDLE -> FILL on Start_Fill_i.
  - IDLE -> DUMP on Start_Dump_i.
  - FILL -> DONE after index 31 is written.
  - DUMP -> DONE after the beat for pair 15 is handshaken.
  - DONE -> IDLE unconditionally.
- Both starts high in IDLE: FILL wins and the dump request is dropped. Starts outside IDLE are ignored and not queued.
- FILL:
  - Counter idx runs 1..31; register 0 is never written.
  - Each FILL cycle drives Reg_Write_o=1, Write_Register_o=idx, Write_Data_o=seed+idx (mod 2^DATA_WIDTH).
  - seed is registered from Seed_i on entry.
- DUMP:
  - Pair counter p runs 0..15; Read_Register_1_o=2p, Read_Register_2_o=2p+1.
  - The output holding register loads {2p, Read_Data_1_i, Read_Data_2_i} when !Dump_Valid_o or Dump_Ready_i; p increments on each load.
  - While Dump_Valid_o && !Dump_Ready_i, index and data are held stable, and p and the read addresses are frozen.
  - Reg_Write_o stays 0 in DUMP.
- All outputs are driven from flops (state, counters, holding register); there is no combinational input-to-output path.
- Reset values: every output is 0; state=IDLE; counters=0; seed=0.
- Reset mid-operation: the engine returns to IDLE at that edge. No further Reg_Write_o, Dump_Valid_o or Done_o is asserted, and any pending dump beat is discarded.

## Timing
- Start sampled at edge k:
  - FILL: state is FILL for cycles k+1..k+31, with Reg_Write_o high in exactly those 31 cycles. Done_o is high in k+32. Busy_o is high k+1..k+32.
  - DUMP with Dump_Ready_i held at 1: addresses for pair p are presented in cycle k+1+p. Dump_Valid_o is high k+2..k+17 (16 beats, one per cycle). Done_o is high in k+18.
- Each ready-low cycle while valid delays every later beat, and Done_o, by one cycle.
- Latency from read address to Dump_Valid_o is 1 cycle. Sustained throughput is 2 registers per cycle.

## Structure
- Shared package rf_pkg holds DATA_WIDTH, ADDR_WIDTH, NUM_REGS and the state enumeration (IDLE/FILL/DUMP/DONE). Other register-file-side blocks reuse these.
- One sub-module, rf_dump_stage, is the valid/ready holding register: load/hold logic, index and both data words.
- The FSM and counters stay in the top module.

## Test plan
- Fill, seed=0x0000_0010 -> 31 writes, reg i holds 0x10+i; reg 0 is never written. Done_o in cycle k+32.
- Fill with seed=0xFFFF_FFF0, then dump with ready=1:
  - Write data wraps: reg 16 = 0x0000_0000 and reg 31 = 0x0000_000F.
  - Dump gives 16 consecutive beats: beat 0 = {0, reg0, reg1}, beat 15 = {30, 0x0000_000E, 0x0000_000F}.
- Dump with ready toggling 1,0,0,1,... -> no beat lost or duplicated; data stays stable while stalled; Done_o appears only after the 16th handshake.
- Start_Fill_i and Start_Dump_i high together -> FILL only, no Dump_Valid_o. Start_Dump_i pulsed during FILL -> ignored, Busy_o drops after Done_o.
- Reset asserted at fill index 10 -> Reg_Write_o is 0 from the next cycle and all outputs are 0. A new Start_Dump_i then completes normally.

Source files
------------

// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry and fill/dump engine state encoding.
package rf_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, FILL, DUMP, DONE} state_t;
endpackage

// File: rtl/rf_dump_stage.sv
// rf_dump_stage: valid/ready holding register for one dump beat (index plus two data words).
module rf_dump_stage
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  ready,
    input  logic [ADDR_WIDTH-1:0] next_index,
    input  logic [DATA_WIDTH-1:0] next_data_1,
    input  logic [DATA_WIDTH-1:0] next_data_2,
    output logic                  load,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] index,
    output logic [DATA_WIDTH-1:0] data_1,
    output logic [DATA_WIDTH-1:0] data_2
);
    assign load = enable && (!valid || ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            index  <= '0;
            data_1 <= '0;
            data_2 <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            index  <= next_index;
            data_1 <= next_data_1;
            data_2 <= next_data_2;
        end else if (ready) begin
            valid  <= 1'b0;
        end
    end
endmodule

// File: rtl/rf_fill_dump_engine.sv
// rf_fill_dump_engine: fills registers 1..31 with seed+index, or dumps all registers in pairs over valid/ready.
module rf_fill_dump_engine
    import rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start_Fill_i,
    input  logic                  Start_Dump_i,
    input  logic [DATA_WIDTH-1:0] Seed_i,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Reg_Write_o,
    output logic [ADDR_WIDTH-1:0] Write_Register_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    output logic [ADDR_WIDTH-1:0] Read_Register_1_o,
    output logic [ADDR_WIDTH-1:0] Read_Register_2_o,
    input  logic [DATA_WIDTH-1:0] Read_Data_1_i,
    input  logic [DATA_WIDTH-1:0] Read_Data_2_i,
    output logic                  Dump_Valid_o,
    input  logic                  Dump_Ready_i,
    output logic [ADDR_WIDTH-1:0] Dump_Index_o,
    output logic [DATA_WIDTH-1:0] Dump_Data_1_o,
    output logic [DATA_WIDTH-1:0] Dump_Data_2_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR_INDEX = ADDR_WIDTH'(NUM_REGS - 2);
    localparam logic [ADDR_WIDTH-1:0] PAIR_END = ADDR_WIDTH'(NUM_REGS / 2);
    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] idx, pair;
    logic [DATA_WIDTH-1:0] seed;
    logic load, fill, dump;
    assign fill = state == FILL;
    assign dump = state == DUMP;
    assign Busy_o = state != IDLE;
    assign Done_o = state == DONE;
    assign Reg_Write_o = fill;
    assign Write_Register_o = fill ? idx : '0;
    assign Write_Data_o = fill ? seed + DATA_WIDTH'(idx) : '0;
    assign Read_Register_1_o = dump ? {pair[ADDR_WIDTH-2:0], 1'b0} : '0;
    assign Read_Register_2_o = dump ? {pair[ADDR_WIDTH-2:0], 1'b1} : '0;
    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = Start_Fill_i ? FILL : Start_Dump_i ? DUMP : IDLE;
            FILL: state_next = idx == LAST_IDX ? DONE : FILL;
            DUMP: state_next = Dump_Valid_o && Dump_Ready_i && Dump_Index_o == LAST_PAIR_INDEX ? DONE : DUMP;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // pair keeps counting to PAIR_END so loading stops once the last pair is captured
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            pair  <= '0;
            seed  <= '0;
        end else begin
            state <= state_next;
            idx   <= state_next == FILL ? (fill ? idx + 1'b1 : ADDR_WIDTH'(1)) : '0;
            pair  <= state_next == DUMP ? pair + ADDR_WIDTH'(load) : '0;
            seed  <= state == IDLE && Start_Fill_i ? Seed_i : seed;
        end
    end
    rf_dump_stage u_stage (
        .clk(clk),
        .rst(reset),
        .enable(dump && pair != PAIR_END),
        .ready(Dump_Ready_i),
        .next_index(Read_Register_1_o),
        .next_data_1(Read_Data_1_i),
        .next_data_2(Read_Data_2_i),
        .load(load),
        .valid(Dump_Valid_o),
        .index(Dump_Index_o),
        .data_1(Dump_Data_1_o),
        .data_2(Dump_Data_2_o)
    );
endmodule

// File: tb/tb_rf_fill_dump_engine.sv
// tb_rf_fill_dump_engine: directed fill/dump scenarios against a behavioural register file.
module tb_rf_fill_dump_engine;
    logic clk = 0, reset = 1;
    logic Start_Fill_i = 0, Start_Dump_i = 0, Dump_Ready_i = 0;
    logic [31:0] Seed_i = 0;
    logic Busy_o, Done_o, Reg_Write_o, Dump_Valid_o;
    logic [4:0] Write_Register_o, Read_Register_1_o, Read_Register_2_o, Dump_Index_o;
    logic [31:0] Write_Data_o, Read_Data_1_i, Read_Data_2_i, Dump_Data_1_o, Dump_Data_2_o;
    logic [31:0] regs [32];
    logic [31:0] exp_mem [32];
    int checks = 0, errors = 0;
    int nwr, first_wr, last_wr, ndone, done_c, last_busy, nvalid, first_valid, beats, beats_at_done;
    bit held;
    logic [69:0] held_vec;

    always #5 clk = ~clk;

    rf_fill_dump_engine dut (
        .clk(clk), .reset(reset), .Start_Fill_i(Start_Fill_i), .Start_Dump_i(Start_Dump_i),
        .Seed_i(Seed_i), .Busy_o(Busy_o), .Done_o(Done_o), .Reg_Write_o(Reg_Write_o),
        .Write_Register_o(Write_Register_o), .Write_Data_o(Write_Data_o),
        .Read_Register_1_o(Read_Register_1_o), .Read_Register_2_o(Read_Register_2_o),
        .Read_Data_1_i(Read_Data_1_i), .Read_Data_2_i(Read_Data_2_i),
        .Dump_Valid_o(Dump_Valid_o), .Dump_Ready_i(Dump_Ready_i), .Dump_Index_o(Dump_Index_o),
        .Dump_Data_1_o(Dump_Data_1_o), .Dump_Data_2_o(Dump_Data_2_o)
    );

    assign Read_Data_1_i = regs[Read_Register_1_o];
    assign Read_Data_2_i = regs[Read_Register_2_o];
    always @(posedge clk) if (Reg_Write_o) regs[Write_Register_o] <= Write_Data_o;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic go(input bit f, input bit d, input logic [31:0] s);
        @(negedge clk);
        Start_Fill_i = f;
        Start_Dump_i = d;
        Seed_i = s;
    endtask

    // cycle c of the run is cycle k+c where k is the edge that sampled the start
    task automatic run(input int ncyc, input bit stall, input int pulse_at, input int rst_at, input bit addr_chk);
        nwr = 0; first_wr = 0; last_wr = 0; ndone = 0; done_c = 0; last_busy = 0;
        nvalid = 0; first_valid = 0; beats = 0; beats_at_done = -1; held = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            Start_Fill_i = 0;
            Start_Dump_i = (c == pulse_at);
            reset = (c == rst_at);
            Dump_Ready_i = stall ? (c % 3 == 1) : 1'b1;
            if (rst_at > 0 && c == rst_at + 1)
                chk("rst_outs", 72'(|{Busy_o, Done_o, Reg_Write_o, Write_Register_o, Write_Data_o,
                    Read_Register_1_o, Read_Register_2_o, Dump_Valid_o, Dump_Index_o,
                    Dump_Data_1_o, Dump_Data_2_o}), 0);
            if (addr_chk && c <= 16) begin
                chk("rd_addr_1", 72'(Read_Register_1_o), 72'(2 * (c - 1)));
                chk("rd_addr_2", 72'(Read_Register_2_o), 72'(2 * (c - 1) + 1));
            end
            if (Reg_Write_o) begin
                nwr++;
                if (first_wr == 0) first_wr = c;
                last_wr = c;
            end
            if (Busy_o) last_busy = c;
            if (Done_o) begin
                ndone++;
                done_c = c;
                beats_at_done = beats;
            end
            if (held) chk("stall_hold", 72'({Dump_Valid_o, Dump_Index_o, Dump_Data_1_o, Dump_Data_2_o}), 72'(held_vec));
            held = 0;
            if (Dump_Valid_o) begin
                nvalid++;
                if (first_valid == 0) first_valid = c;
                if (Dump_Ready_i) begin
                    if (beats < 16) begin
                        chk("beat_index", 72'(Dump_Index_o), 72'(2 * beats));
                        chk("beat_data_1", 72'(Dump_Data_1_o), 72'(exp_mem[2 * beats]));
                        chk("beat_data_2", 72'(Dump_Data_2_o), 72'(exp_mem[2 * beats + 1]));
                    end else chk("extra_beat", 72'(beats), 72'(15));
                    beats++;
                end else begin
                    held = 1;
                    held_vec = {Dump_Valid_o, Dump_Index_o, Dump_Data_1_o, Dump_Data_2_o};
                end
            end
        end
        reset = 0;
    endtask

    task automatic model_fill(input logic [31:0] s, input int n);
        for (int i = 1; i <= n; i++) exp_mem[i] = s + 32'(i);
    endtask

    task automatic chk_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < 32; i++) if (regs[i] !== exp_mem[i]) bad++;
        chk(tag, 72'(bad), 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs[i] = 32'hBAD0_0000 + 32'(i);
            exp_mem[i] = regs[i];
        end
        regs[0] = 32'h5A5A_0000;
        exp_mem[0] = 32'h5A5A_0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 72'(Busy_o), 0);
        chk("rst_done", 72'(Done_o), 0);
        chk("rst_we", 72'(Reg_Write_o), 0);
        chk("rst_valid", 72'(Dump_Valid_o), 0);
        chk("rst_wdata", 72'(Write_Data_o), 0);
        reset = 0;

        go(1, 0, 32'h0000_0010);
        run(40, 0, 0, 0, 0);
        model_fill(32'h0000_0010, 31);
        chk("fill_nwr", 72'(nwr), 31);
        chk("fill_first_wr", 72'(first_wr), 1);
        chk("fill_last_wr", 72'(last_wr), 31);
        chk("fill_done_cyc", 72'(done_c), 32);
        chk("fill_ndone", 72'(ndone), 1);
        chk("fill_busy_end", 72'(last_busy), 32);
        chk("fill_reg0", 72'(regs[0]), 72'h5A5A_0000);
        chk("fill_reg5", 72'(regs[5]), 72'h15);
        chk("fill_reg31", 72'(regs[31]), 72'h2F);
        chk_mem("fill_mem");

        go(1, 0, 32'hFFFF_FFF0);
        run(40, 0, 0, 0, 0);
        model_fill(32'hFFFF_FFF0, 31);
        chk("wrap_reg16", 72'(regs[16]), 0);
        chk("wrap_reg31", 72'(regs[31]), 72'hF);
        chk("wrap_reg1", 72'(regs[1]), 72'hFFFF_FFF1);
        chk_mem("wrap_mem");

        go(0, 1, 0);
        run(30, 0, 0, 0, 1);
        chk("dump_first_valid", 72'(first_valid), 2);
        chk("dump_nvalid", 72'(nvalid), 16);
        chk("dump_beats", 72'(beats), 16);
        chk("dump_done_cyc", 72'(done_c), 18);
        chk("dump_busy_end", 72'(last_busy), 18);
        chk("dump_nwr", 72'(nwr), 0);

        go(0, 1, 0);
        run(70, 1, 0, 0, 0);
        chk("stall_beats", 72'(beats), 16);
        chk("stall_ndone", 72'(ndone), 1);
        chk("stall_beats_at_done", 72'(beats_at_done), 16);
        chk("stall_done_cyc", 72'(done_c), 50);
        chk("stall_nwr", 72'(nwr), 0);

        go(1, 1, 32'h0000_0777);
        run(40, 0, 5, 0, 0);
        model_fill(32'h0000_0777, 31);
        chk("both_nwr", 72'(nwr), 31);
        chk("both_nvalid", 72'(nvalid), 0);
        chk("both_done_cyc", 72'(done_c), 32);
        chk("both_busy_end", 72'(last_busy), 32);
        chk_mem("both_mem");

        go(1, 0, 32'h0000_0100);
        run(40, 0, 0, 10, 0);
        model_fill(32'h0000_0100, 10);
        chk("rstmid_nwr", 72'(nwr), 10);
        chk("rstmid_last_wr", 72'(last_wr), 10);
        chk("rstmid_ndone", 72'(ndone), 0);
        chk("rstmid_busy_end", 72'(last_busy), 10);
        chk_mem("rstmid_mem");

        go(0, 1, 0);
        run(30, 0, 0, 0, 1);
        chk("redump_nvalid", 72'(nvalid), 16);
        chk("redump_beats", 72'(beats), 16);
        chk("redump_done_cyc", 72'(done_c), 18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
